// File: rtl/updown_mod_counter.sv
// Up/down modulo-MOD counter with wrap/saturate modes, load, clear, terminal-count pulse and
// sticky ovf/unf flags. Define COUNTER_MATCH_EN to add the registered match_val compare.
module updown_mod_counter #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned MOD   = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic             load_en,
   input  logic [WIDTH-1:0] load,
   input  logic             up_down,
   input  logic             sat,
`ifdef COUNTER_MATCH_EN
   input  logic [WIDTH-1:0] match_val,
   output logic             match,
`endif
   output logic [WIDTH-1:0] cnt,
   output logic             tc,
   output logic             ovf,
   output logic             unf
);

   localparam logic [WIDTH:0] MaxExt = (WIDTH + 1)'(MOD - 1);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             tc_q, tc_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   logic [WIDTH:0] cnt_ext;
   logic [WIDTH:0] load_ext;
   logic [WIDTH:0] inc;
   logic [WIDTH:0] dec;

   // One extra bit so that MAX+1 and 0-1 are visible without wrapping through 2**WIDTH.
   assign cnt_ext  = {1'b0, cnt_q};
   assign load_ext = {1'b0, load};
   assign inc      = cnt_ext + 1'b1;
   assign dec      = cnt_ext - 1'b1;

   always_comb begin
      cnt_d = cnt_q;
      tc_d  = 1'b0;
      ovf_d = ovf_q;
      unf_d = unf_q;
      if (clr) begin
         cnt_d = '0;
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end else if (load_en) begin
         cnt_d = (load_ext > MaxExt) ? MaxExt[WIDTH-1:0] : load;
      end else if (en) begin
         if (up_down) begin
            if (inc > MaxExt) begin
               ovf_d = 1'b1;
               tc_d  = 1'b1;
               cnt_d = sat ? MaxExt[WIDTH-1:0] : '0;
            end else begin
               cnt_d = inc[WIDTH-1:0];
            end
         end else begin
            // Borrow out of the extra bit means we were at zero.
            if (dec[WIDTH]) begin
               unf_d = 1'b1;
               tc_d  = 1'b1;
               cnt_d = sat ? '0 : MaxExt[WIDTH-1:0];
            end else begin
               cnt_d = dec[WIDTH-1:0];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         tc_q  <= 1'b0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tc_q  <= tc_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign cnt = cnt_q;
   assign tc  = tc_q;
   assign ovf = ovf_q;
   assign unf = unf_q;

`ifdef COUNTER_MATCH_EN
   logic match_q, match_d;

   // Compares the count currently presented, so match trails cnt by one cycle.
   assign match_d = clr ? 1'b0 : (cnt_q == match_val);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         match_q <= 1'b0;
      end else begin
         match_q <= match_d;
      end
   end

   assign match = match_q;
`endif

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench for updown_mod_counter (WIDTH=4, MOD=10); covers match when COUNTER_MATCH_EN
// is defined.
module tb_updown_mod_counter;

   localparam int unsigned WIDTH = 4;
   localparam int unsigned MOD   = 10;
   localparam int unsigned MAX   = MOD - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             clr;
   logic             en;
   logic             load_en;
   logic [WIDTH-1:0] load;
   logic             up_down;
   logic             sat;
   logic [WIDTH-1:0] cnt;
   logic             tc;
   logic             ovf;
   logic             unf;
`ifdef COUNTER_MATCH_EN
   logic [WIDTH-1:0] match_val;
   logic             match;
`endif

   updown_mod_counter #(
      .WIDTH(WIDTH),
      .MOD  (MOD)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .en       (en),
      .load_en  (load_en),
      .load     (load),
      .up_down  (up_down),
      .sat      (sat),
`ifdef COUNTER_MATCH_EN
      .match_val(match_val),
      .match    (match),
`endif
      .cnt      (cnt),
      .tc       (tc),
      .ovf      (ovf),
      .unf      (unf)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned cnt;
      bit          tc;
      bit          ovf;
      bit          unf;
      bit          match;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int unsigned m_cnt    = 0;
   bit          m_ovf    = 1'b0;
   bit          m_unf    = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, expv, $time);
      end
   endtask

   task automatic compare_out();
      exp_t x;
      if (exp_q.size() == 0) begin
         check("sb_empty", 32'd1, 32'd0);
      end else begin
         x = exp_q.pop_front();
         check("cnt", 32'(cnt), 32'(x.cnt));
         check("tc", 32'(tc), 32'(x.tc));
         check("ovf", 32'(ovf), 32'(x.ovf));
         check("unf", 32'(unf), 32'(x.unf));
`ifdef COUNTER_MATCH_EN
         check("match", 32'(match), 32'(x.match));
`endif
      end
   endtask

   // Drive one cycle of stimulus, predict the result, then compare just after the edge.
   task automatic step(input logic c, input logic le, input logic [WIDTH-1:0] lv,
                       input logic e, input logic ud, input logic s);
      exp_t x;
      clr     = c;
      load_en = le;
      load    = lv;
      en      = e;
      up_down = ud;
      sat     = s;
      x.tc    = 1'b0;
      x.match = 1'b0;
`ifdef COUNTER_MATCH_EN
      x.match = !c && (m_cnt == int'(match_val));
`endif
      if (c) begin
         m_cnt = 0;
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else if (le) begin
         m_cnt = (int'(lv) > int'(MAX)) ? MAX : int'(lv);
      end else if (e) begin
         if (ud) begin
            if (m_cnt == MAX) begin
               m_ovf = 1'b1;
               x.tc  = 1'b1;
               m_cnt = s ? MAX : 0;
            end else begin
               m_cnt = m_cnt + 1;
            end
         end else begin
            if (m_cnt == 0) begin
               m_unf = 1'b1;
               x.tc  = 1'b1;
               m_cnt = s ? 0 : MAX;
            end else begin
               m_cnt = m_cnt - 1;
            end
         end
      end
      x.cnt = m_cnt;
      x.ovf = m_ovf;
      x.unf = m_unf;
      exp_q.push_back(x);
      @(posedge clk);
      #1;
      compare_out();
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int tc_cnt;
      rst     = 1'b0;
      clr     = 1'b0;
      en      = 1'b0;
      load_en = 1'b0;
      load    = '0;
      up_down = 1'b0;
      sat     = 1'b0;
`ifdef COUNTER_MATCH_EN
      match_val = 4'd5;
`endif
      #12;
      check("rst_cnt", 32'(cnt), 32'd0);
      check("rst_tc", 32'(tc), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      check("rst_unf", 32'(unf), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // Up-count with wrap: 1..9, 0, 1, 2 with a single tc pulse.
      tc_cnt = 0;
      repeat (12) begin
         step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
         if (tc === 1'b1) tc_cnt++;
      end
      check("wrap_tc_pulses", 32'(tc_cnt), 32'd1);
      check("wrap_cnt", 32'(cnt), 32'd2);
      check("wrap_ovf", 32'(ovf), 32'd1);
      check("wrap_unf", 32'(unf), 32'd0);

      // Down-count saturating at zero.
      step(1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1);
      repeat (4) step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
      check("sat_cnt", 32'(cnt), 32'd0);
      check("sat_tc", 32'(tc), 32'd1);
      check("sat_unf", 32'(unf), 32'd1);

      // Load clamp beats count; clear beats load.
      step(1'b0, 1'b1, 4'd14, 1'b1, 1'b1, 1'b0);
      check("clamp_cnt", 32'(cnt), 32'd9);
      step(1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
      check("clr_cnt", 32'(cnt), 32'd0);
      check("clr_ovf", 32'(ovf), 32'd0);
      check("clr_unf", 32'(unf), 32'd0);

      // Direction change at the bounds in wrap mode.
      step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      check("dn_wrap_cnt", 32'(cnt), 32'd9);
      check("dn_wrap_unf", 32'(unf), 32'd1);
      step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
      check("up_wrap_cnt", 32'(cnt), 32'd0);
      check("up_wrap_ovf", 32'(ovf), 32'd1);
      check("up_wrap_unf", 32'(unf), 32'd1);

      // Asynchronous reset between edges.
      repeat (6) step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
      check("pre_rst_cnt", 32'(cnt), 32'd6);
      #3;
      rst = 1'b0;
      #1;
      check("arst_cnt", 32'(cnt), 32'd0);
      check("arst_ovf", 32'(ovf), 32'd0);
      check("arst_unf", 32'(unf), 32'd0);
      m_cnt = 0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("arst_hold_cnt", 32'(cnt), 32'd0);
      check("arst_hold_ovf", 32'(ovf), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
      check("post_rst_cnt", 32'(cnt), 32'd1);

`ifdef COUNTER_MATCH_EN
      // match follows cnt == 5 by one cycle, exactly once in a 0..9 sweep.
      match_val = 4'd5;
      step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      tc_cnt = 0;
      repeat (9) begin
         step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
         if (match === 1'b1) tc_cnt++;
      end
      check("match_pulses", 32'(tc_cnt), 32'd1);
`endif

      // Random mix of all controls.
      repeat (80) begin
`ifdef COUNTER_MATCH_EN
         match_val = 4'($urandom_range(0, 9));
`endif
         step(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 7) == 0),
              4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
